// File: rtl/spi_apb_pkg.sv
// Purpose: shared state encoding and frame field positions for the SPI host feeding spi2apb_bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package spi_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Frame layout: {rw, addr[6:0], data[7:0]}, sent MSB first
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam int DEFAULT_CLK_DIV = 2;

    // Counts SCLK falling edges 0..16
    localparam int BIT_CNT_W = 5;

endpackage

// File: rtl/spi_half_tick.sv
// Purpose: SCLK half-period timer; tick marks the last clk cycle of the current phase.
// Latency: tick asserts CLK_DIV-1 cycles after the counter is cleared.
// Backpressure: none; clr restarts the phase on every state entry.
module spi_half_tick
    import spi_apb_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    // Count 0..CLK_DIV-1, wrapping at the phase boundary or restarting on state entry
    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_apb_host.sv
// Purpose: SPI mode-0 master issuing one 16-bit {rw, addr, data} frame per request to spi2apb_bridge.
// Latency: done pulses 1+35*CLK_DIV cycles after start is sampled in IDLE; rdata valid in that cycle.
// Backpressure: start is only taken in IDLE; while busy it is dropped (err pulse if SPI_APB_HOST_BUSY_ERR_EN).
module spi_apb_host
    import spi_apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 8,
    parameter int CLK_DIV     = DEFAULT_CLK_DIV
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rw,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [PDATA_WIDTH-1:0] wdata,
    output logic                   busy,
    output logic                   done,
    output logic [PDATA_WIDTH-1:0] rdata,
`ifdef SPI_APB_HOST_BUSY_ERR_EN
    output logic                   err,
`endif
    output logic                   sclk,
    output logic                   ss,
    output logic                   mosi,
    input  logic                   miso
);

    spi_state_e             state_q;
    spi_state_e             state_d;
    logic                   tick;
    logic                   accept;
    logic                   fall;
    logic                   finish;
    logic [DATA_WIDTH-1:0]  frame;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [PDATA_WIDTH-1:0] cap_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;

    assign accept = (state_q == ST_IDLE) && start;
    // End of an SCLK high phase: miso is sampled and mosi advances on this edge
    assign fall   = (state_q == ST_HIGH) && tick;
    assign finish = (state_q == ST_GAP) && tick;
    // mosi comes straight off the shift register MSB, so it only moves on load or SCLK fall
    assign mosi   = shift_q[DATA_WIDTH-1];

    // Assemble the outgoing frame; reads carry a zero data field
    always_comb begin
        frame                    = '0;
        frame[RW_BIT]            = rw;
        frame[ADDR_MSB:ADDR_LSB] = addr;
        if (rw) begin
            frame[DATA_MSB:0] = wdata;
        end
    end

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk   (clk),
        .reset (reset),
        .clr   ((state_q == ST_IDLE) || (state_d != state_q)),
        .tick  (tick)
    );

    // Next-state: every non-idle state lasts exactly one half-period
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SETUP;
            ST_SETUP: if (tick)  state_d = ST_HIGH;
            ST_HIGH:  if (tick)  state_d = ST_LOW;
            ST_LOW:   if (tick)  state_d = (bit_cnt_q < BIT_CNT_W'(DATA_WIDTH)) ? ST_HIGH : ST_HOLD;
            ST_HOLD:  if (tick)  state_d = ST_GAP;
            ST_GAP:   if (tick)  state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pin outputs registered from the next state so ss/sclk never glitch; shift and capture datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            ss        <= 1'b1;
            sclk      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            shift_q   <= '0;
            cap_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            ss   <= !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW, ST_HOLD});
            sclk <= (state_d == ST_HIGH);
            busy <= (state_d != ST_IDLE);
            done <= finish;
            if (accept) begin
                shift_q   <= frame;
                cap_q     <= '0;
                bit_cnt_q <= '0;
            end
            if (fall) begin
                shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                // Only the trailing data byte is ever reported, so only it is kept
                cap_q     <= {cap_q[PDATA_WIDTH-2:0], miso};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (finish) begin
                rdata <= cap_q;
            end
        end
    end

`ifdef SPI_APB_HOST_BUSY_ERR_EN
    // Flag a request that arrives while a frame is in flight; the request itself is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= start && (state_q != ST_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_spi_apb_host.sv
// Purpose: self-checking bench for spi_apb_host (CLK_DIV=2 instance plus a CLK_DIV=1 instance).
// Latency: expectations derive from the frame timeline t = cycle - start cycle.
// Backpressure: mid-frame starts are exercised; err checked when SPI_APB_HOST_BUSY_ERR_EN is defined.
module tb_spi_apb_host;

    localparam int D  = 2;
    localparam int D1 = 1;

    logic       clk, reset, start, rw, miso;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       busy, done, sclk, ss, mosi;
    logic       start1, rw1, miso1;
    logic [6:0] addr1;
    logic [7:0] wdata1, rdata1;
    logic       busy1, done1, sclk1, ss1, mosi1;
`ifdef SPI_APB_HOST_BUSY_ERR_EN
    logic       err, err1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic        m_act = 1'b0;
    int          m_fs  = 0;
    logic [15:0] m_frame = '0, m_reply = '0, drv_reply = '0;
    logic [7:0]  exp_rdata = '0;
    logic        exp_err = 1'b0;

    // Bus monitor results
    logic [15:0] mon_word = '0;
    int mon_pulses = 0, ss_fall = -1, ss_rise = -1, done_cyc = -1, done_cnt = 0;
    int err_cyc = -1, err_cnt = 0;

    spi_apb_host #(.CLK_DIV(D)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata),
`ifdef SPI_APB_HOST_BUSY_ERR_EN
        .err(err),
`endif
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso)
    );

    spi_apb_host #(.CLK_DIV(D1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
        .busy(busy1), .done(done1), .rdata(rdata1),
`ifdef SPI_APB_HOST_BUSY_ERR_EN
        .err(err1),
`endif
        .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model + per-cycle compare + monitor, evaluated 1 time unit after each rising edge
    initial begin
        logic eb, ed, es, ek, em, ee, got_err;
        int t, j;
        logic p_ss, p_sclk;
        p_ss = 1'b1;
        p_sclk = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            // inputs still hold the values sampled at this edge
            exp_err = 1'b0;
            if (reset) begin
                m_act = 1'b0;
                exp_rdata = '0;
            end else begin
                if (start) begin
                    if (!m_act || (cyc - 1 - m_fs) > 35 * D) begin
                        m_act   = 1'b1;
                        m_fs    = cyc - 1;
                        m_frame = {rw, addr, rw ? wdata : 8'h00};
                        m_reply = drv_reply;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                if (m_act && (cyc - m_fs) == 35 * D + 1) exp_rdata = m_reply[7:0];
            end
            eb = 1'b0; ed = 1'b0; es = 1'b1; ek = 1'b0; em = 1'b0;
            t = cyc - m_fs;
            if (m_act && t >= 1 && t <= 35 * D) begin
                eb = 1'b1;
                es = (t > 34 * D);
                if (t >= 1 + D && t <= 33 * D) ek = (((t - 1 - D) / D) % 2 == 0);
                j = (t - 1) / (2 * D);
                em = (j < 16) ? m_frame[4'(15 - j)] : 1'b0;
            end else if (m_act && t == 35 * D + 1) begin
                ed = 1'b1;
            end
`ifdef SPI_APB_HOST_BUSY_ERR_EN
            got_err = err;
            ee = exp_err;
`else
            got_err = 1'b0;
            ee = 1'b0;
`endif
            check($sformatf("outputs@%0d {busy,done,ss,sclk,mosi,err,rdata}", cyc),
                  {busy, done, ss, sclk, mosi, got_err, rdata},
                  {eb, ed, es, ek, em, ee, exp_rdata});
            if (p_ss && !ss) begin ss_fall = cyc; mon_word = '0; mon_pulses = 0; end
            if (!p_ss && ss) ss_rise = cyc;
            if (!p_sclk && sclk) begin mon_word = {mon_word[14:0], mosi}; mon_pulses++; end
            if (done) begin done_cyc = cyc; done_cnt++; end
            if (got_err) begin err_cyc = cyc; err_cnt++; end
            p_ss = ss;
            p_sclk = sclk;
        end
    end

    // Mode-0 slave: presents reply MSB first, advancing after each SCLK fall
    initial begin
        int s_idx;
        logic s_prev;
        s_idx = 0;
        s_prev = 1'b0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (ss) s_idx = 0;
            else if (s_prev && !sclk) s_idx++;
            s_prev = sclk;
            miso = (!ss && s_idx < 16) ? m_reply[4'(15 - s_idx)] : 1'b0;
        end
    end

    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input logic [15:0] rep);
        rw = r; addr = a; wdata = d; drv_reply = rep; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n;
        n = 0;
        dc = -1;
        while (!done && n < 300) begin @(negedge clk); n++; end
        if (done) dc = cyc;
        else begin
            checks++; errors++;
            $display("FAIL wait_done: no done within %0d cycles", n);
        end
    endtask

    initial begin
        int fs, dc, base_done, base_err, base_fall, n, c0, c1, rise, fall, kind, off;
        logic r;
        logic [6:0] a;
        logic [7:0] d;
        logic [15:0] rep;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        start1 = 1'b0; rw1 = 1'b1; addr1 = '0; wdata1 = '0; miso1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state {ss,sclk,busy,done,mosi,rdata}", {ss, sclk, busy, done, mosi, rdata}, {1'b1, 4'b0000, 8'h00});
        reset = 1'b0;
        @(negedge clk);

        // Write 7f/ff: all-ones frame and the reference timeline for CLK_DIV=2
        fs = cyc;
        issue(1'b1, 7'h7f, 8'hff, 16'h1234);
        wait_done(dc);
        check("t1_done_cycle", dc - fs, 71);
        check("t1_ss_fall_cycle", ss_fall - fs, 1);
        check("t1_ss_last_low_cycle", ss_rise - 1 - fs, 68);
        check("t1_mosi_word", mon_word, 16'hFFFF);
        check("t1_sclk_pulses", mon_pulses, 16);
        @(negedge clk);

        // Write 2A/55
        issue(1'b1, 7'h2A, 8'h55, 16'hFFFF);
        wait_done(dc);
        check("t2_mosi_word", mon_word, 16'hAA55);
        check("t2_sclk_pulses", mon_pulses, 16);
        @(negedge clk);

        // Read 05: data field zero on mosi, slave byte lands in rdata
        issue(1'b0, 7'h05, 8'h99, 16'hA73C);
        wait_done(dc);
        check("t3_mosi_word", mon_word, 16'h0500);
        check("t3_rdata", rdata, 8'h3C);
        @(negedge clk);

        // start pulsed at cycle 20 of a frame must be dropped
        fs = cyc;
        base_done = done_cnt;
        base_err = err_cnt;
        issue(1'b1, 7'h11, 8'h22, 16'h0000);
        while (cyc < fs + 20) @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h6b; wdata = 8'hc3;
        @(negedge clk);
        start = 1'b0;
        wait_done(dc);
        check("t4_done_cycle", dc - fs, 71);
        check("t4_mosi_word", mon_word, 16'h9122);
        base_fall = ss_fall;
        repeat (100) @(negedge clk);
        check("t4_done_count", done_cnt - base_done, 1);
        check("t4_no_second_frame", ss_fall, base_fall);
`ifdef SPI_APB_HOST_BUSY_ERR_EN
        check("t4_err_cycle", err_cyc - fs, 21);
        check("t4_err_count", err_cnt - base_err, 1);
`endif

        // reset at cycle 30 aborts the frame without done
        fs = cyc;
        issue(1'b1, 7'h33, 8'h44, 16'h0000);
        base_done = done_cnt;
        while (cyc < fs + 30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_ss", ss, 1'b1);
        check("t5_sclk", sclk, 1'b0);
        check("t5_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("t5_no_done", done_cnt - base_done, 0);

        // Randomized frames: random gaps (0 = start in the done cycle), stray starts, resets
        for (int i = 0; i < 24; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 7'($urandom);
            d = 8'($urandom);
            rep = 16'($urandom);
            fs = cyc;
            issue(r, a, d, rep);
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                off = $urandom_range(2, 69);
                while (cyc < fs + off) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                if (kind == 1) begin
                    off = $urandom_range(2, 70);
                    while (cyc < fs + off) @(negedge clk);
                    start = 1'b1; rw = ~r; addr = 7'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                end
                wait_done(dc);
                check("rand_done_cycle", dc - fs, 71);
                check("rand_mosi_word", mon_word, {r, a, r ? d : 8'h00});
                check("rand_sclk_pulses", mon_pulses, 16);
                check("rand_rdata", rdata, rep[7:0]);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        // CLK_DIV=1: start-to-done and back-to-back spacing
        @(negedge clk);
        c0 = cyc;
        addr1 = 7'h15; wdata1 = 8'h6e; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        rise = -1;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
            if (ss1 && rise < 0) rise = cyc;
        end
        check("d1_first_latency", cyc - c0, 36);
        c1 = cyc;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        fall = ss1 ? -1 : cyc;
        // ss is high through GAP (1+34*D1) and the done cycle (1+35*D1); falls the cycle after done
        check("d1_ss_rise_to_fall", fall - rise, (1 + 35 * D1 + 1) - (1 + 34 * D1));
        n = 0;
        while (!done1 && n < 200) begin @(negedge clk); n++; end
        check("d1_second_latency", cyc - c1, 36);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
